// File: rtl/aes_host_ctrl_if.sv
// aes_host_ctrl_if: byte streams and aes_core load/busy bus seen by the host controller
interface aes_host_ctrl_if;
    logic [7:0]   rx_data_i;
    logic         rx_valid_i;
    logic         rx_ready_o;
    logic [7:0]   tx_data_o;
    logic         tx_valid_o;
    logic         tx_ready_i;
    logic         aes_load_o;
    logic [255:0] aes_key_o;
    logic [127:0] aes_data_o;
    logic [1:0]   aes_size_o;
    logic         aes_dec_o;
    logic [127:0] aes_result_i;
    logic         aes_busy_i;
    logic         err_o;
    logic         idle_o;

    modport slave (
        input  rx_data_i, rx_valid_i, tx_ready_i, aes_result_i, aes_busy_i,
        output rx_ready_o, tx_data_o, tx_valid_o, aes_load_o, aes_key_o,
               aes_data_o, aes_size_o, aes_dec_o, err_o, idle_o
    );

    modport master (
        output rx_data_i, rx_valid_i, tx_ready_i, aes_result_i, aes_busy_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, aes_load_o, aes_key_o,
               aes_data_o, aes_size_o, aes_dec_o, err_o, idle_o
    );
endinterface

// File: rtl/aes_host_ctrl.sv
// aes_host_ctrl: byte-serial command/key/data front-end that loads aes_core and streams back the result
module aes_host_ctrl #(
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           reset,
    aes_host_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_DATA, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE, S_SEND
    } state_t;

    state_t         r_state, w_next;
    logic [4:0]     r_cnt;
    logic [TW-1:0]  r_tmo;
    logic [255:0]   r_key;
    logic [127:0]   r_data, r_result;
    logic [1:0]     r_size;
    logic           r_dec, r_err;
    logic           w_rx_xfer, w_tx_xfer, w_timeout, w_abort;
    logic [4:0]     w_key_last;
    logic [7:0]     w_key_idx;
    logic [6:0]     w_data_idx;

    assign bus.rx_ready_o = (r_state == S_IDLE) || (r_state == S_KEY) || (r_state == S_DATA);
    assign bus.tx_valid_o = r_state == S_SEND;
    assign bus.tx_data_o  = r_result[127:120];
    assign bus.aes_load_o = r_state == S_LOAD;
    assign bus.idle_o     = r_state == S_IDLE;
    assign bus.aes_key_o  = r_key;
    assign bus.aes_data_o = r_data;
    assign bus.aes_size_o = r_size;
    assign bus.aes_dec_o  = r_dec;
    assign bus.err_o      = r_err;

    assign w_rx_xfer  = bus.rx_valid_i && bus.rx_ready_o;
    assign w_tx_xfer  = bus.tx_valid_o && bus.tx_ready_i;
    assign w_timeout  = r_tmo == TW'(TIMEOUT - 1);
    assign w_abort    = w_timeout && (((r_state == S_WAIT_BUSY) && !bus.aes_busy_i) ||
                                      ((r_state == S_WAIT_DONE) && bus.aes_busy_i));
    assign w_key_last = (r_size == 2'd0) ? 5'd15 : (r_size == 2'd1) ? 5'd23 : 5'd31;
    assign w_key_idx  = 8'd255 - {r_cnt, 3'b000};
    assign w_data_idx = 7'd127 - {r_cnt[3:0], 3'b000};

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = w_rx_xfer ? (bus.rx_data_i[3] ? S_KEY : S_DATA) : S_IDLE;
            S_KEY:       w_next = (w_rx_xfer && r_cnt == w_key_last) ? S_DATA : S_KEY;
            S_DATA:      w_next = (w_rx_xfer && r_cnt == 5'd15) ? S_LOAD : S_DATA;
            S_LOAD:      w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: w_next = bus.aes_busy_i ? S_WAIT_DONE : (w_abort ? S_IDLE : S_WAIT_BUSY);
            S_WAIT_DONE: w_next = !bus.aes_busy_i ? S_SEND : (w_abort ? S_IDLE : S_WAIT_DONE);
            S_SEND:      w_next = (w_tx_xfer && r_cnt == 5'd15) ? S_IDLE : S_SEND;
            default:     w_next = S_IDLE;
        endcase
    end

    // byte/timeout counters and the key, data, result and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_key    <= '0;
            r_data   <= '0;
            r_result <= '0;
            r_size   <= '0;
            r_dec    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_cnt <= (w_next != r_state) ? 5'd0 : r_cnt + 5'(w_rx_xfer || w_tx_xfer);
            r_tmo <= (w_next != r_state || !(r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE)) ? '0 : r_tmo + 1'b1;
            if (r_state == S_IDLE && w_rx_xfer) begin
                r_size <= bus.rx_data_i[1:0];
                r_dec  <= bus.rx_data_i[2];
                r_err  <= 1'b0;
                if (bus.rx_data_i[3]) r_key <= '0;
            end
            if (r_state == S_KEY && w_rx_xfer) r_key[w_key_idx -: 8] <= bus.rx_data_i;
            if (r_state == S_DATA && w_rx_xfer) r_data[w_data_idx -: 8] <= bus.rx_data_i;
            if (w_abort) r_err <= 1'b1;
            if (r_state == S_WAIT_DONE && !bus.aes_busy_i) r_result <= bus.aes_result_i;
            if (w_tx_xfer) r_result <= {r_result[119:0], 8'h00};
        end
    end
endmodule
